// File: rtl/master_port_if.sv
// Host request and bit-serial slave bus signals for master_port.
// The master modport is the initiator's view; slave is the host/slave side.
interface master_port_if #(
  parameter int unsigned N   = 8,
  parameter int unsigned ADN = 12
);
  logic           start;
  logic           rw;
  logic [ADN-1:0] addr_in;
  logic [N-1:0]   wdata_in;
  logic           busy;
  logic           done;
  logic           err;
  logic [N-1:0]   rdata;
  logic           validOut;
  logic           wren;
  logic           Address;
  logic           DataOut;
  logic           ready;
  logic           validIn;
  logic           DataIn;

  modport master (
    input  start, rw, addr_in, wdata_in, ready, validIn, DataIn,
    output busy, done, err, rdata, validOut, wren, Address, DataOut
  );

  modport slave (
    output start, rw, addr_in, wdata_in, ready, validIn, DataIn,
    input  busy, done, err, rdata, validOut, wren, Address, DataOut
  );
endinterface

// File: rtl/master_port.sv
// Bit-serial bus initiator: serializes a host request, collects serial read data.
// Define MASTER_TIMEOUT_EN to bound the WRDY/RWAIT waits by TIMEOUT cycles.
module master_port #(
  parameter int unsigned N       = 8,
  parameter int unsigned ADN     = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  master_port_if.master bus
);
  localparam int unsigned BitW  = $clog2(ADN + 1);
  localparam int unsigned BeatW = $clog2(N + 1);

  if (ADN < N || TIMEOUT == 0) begin : gen_param_check
    $error("master_port: requires ADN >= N and TIMEOUT > 0");
  end

  typedef enum logic [2:0] {StIdle, StWrdy, StReq, StAddr, StRwait} state_e;

  state_e           stateQ, stateD;
  logic             rwQ, rwD;
  logic [ADN-1:0]   addrShQ, addrShD;
  logic [ADN-1:0]   dataShQ, dataShD;
  logic [BitW-1:0]  bitCntQ, bitCntD;
  logic [BeatW-1:0] beatCntQ, beatCntD;
  logic [N-1:0]     rdShQ, rdShD;
  logic [N-1:0]     rdataQ, rdataD;
  logic             busyQ, busyD, doneQ, doneD, validQ, validD, wrenQ, wrenD;
  logic             addrBitQ, addrBitD, dataBitQ, dataBitD;

`ifdef MASTER_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  logic [WaitW-1:0] waitQ, waitD;
  logic             errQ, errD;
  logic             timeout;
  assign timeout = (waitQ == WaitW'(TIMEOUT - 1));
`endif

  always_comb begin
    stateD   = stateQ;
    rwD      = rwQ;
    addrShD  = addrShQ;
    dataShD  = dataShQ;
    bitCntD  = bitCntQ;
    beatCntD = beatCntQ;
    rdShD    = rdShQ;
    rdataD   = rdataQ;
    busyD    = busyQ;
    doneD    = 1'b0;
    validD   = 1'b0;
    wrenD    = 1'b0;
    addrBitD = 1'b0;
    dataBitD = 1'b0;
`ifdef MASTER_TIMEOUT_EN
    waitD    = waitQ;
    errD     = 1'b0;
`endif
    unique case (stateQ)
      StIdle: begin
        busyD = 1'b0;
        if (bus.start) begin
          rwD     = bus.rw;
          addrShD = bus.addr_in;
          // Write data sits in the low N bits so it leaves on the last N address beats.
          dataShD = bus.rw ? ADN'(bus.wdata_in) : '0;
          busyD   = 1'b1;
          stateD  = StWrdy;
`ifdef MASTER_TIMEOUT_EN
          waitD   = '0;
`endif
        end
      end
      StWrdy: begin
        if (bus.ready) begin
          stateD = StReq;
          validD = 1'b1;
          wrenD  = rwQ;
        end else begin
`ifdef MASTER_TIMEOUT_EN
          if (timeout) begin
            stateD = StIdle;
            busyD  = 1'b0;
            doneD  = 1'b1;
            errD   = 1'b1;
          end else begin
            waitD = waitQ + 1'b1;
          end
`endif
        end
      end
      StReq: begin
        stateD   = StAddr;
        bitCntD  = '0;
        validD   = 1'b1;
        wrenD    = rwQ;
        addrBitD = addrShQ[ADN-1];
        dataBitD = dataShQ[ADN-1];
        addrShD  = addrShQ << 1;
        dataShD  = dataShQ << 1;
      end
      StAddr: begin
        if (bitCntQ == BitW'(ADN - 1)) begin
          if (rwQ) begin
            stateD = StIdle;
            busyD  = 1'b0;
            doneD  = 1'b1;
          end else begin
            stateD   = StRwait;
            beatCntD = '0;
            wrenD    = rwQ;
`ifdef MASTER_TIMEOUT_EN
            waitD    = '0;
`endif
          end
        end else begin
          bitCntD  = bitCntQ + 1'b1;
          validD   = 1'b1;
          wrenD    = rwQ;
          addrBitD = addrShQ[ADN-1];
          dataBitD = dataShQ[ADN-1];
          addrShD  = addrShQ << 1;
          dataShD  = dataShQ << 1;
        end
      end
      StRwait: begin
        wrenD = rwQ;
        if (bus.validIn) begin
`ifdef MASTER_TIMEOUT_EN
          waitD = '0;
`endif
          // Beat 0 is the slave's dummy beat and is not shifted in.
          if (beatCntQ != '0) rdShD = N'({rdShQ, bus.DataIn});
          if (beatCntQ == BeatW'(N)) begin
            stateD = StIdle;
            busyD  = 1'b0;
            doneD  = 1'b1;
            rdataD = N'({rdShQ, bus.DataIn});
          end else begin
            beatCntD = beatCntQ + 1'b1;
          end
        end else begin
`ifdef MASTER_TIMEOUT_EN
          if (timeout) begin
            stateD = StIdle;
            busyD  = 1'b0;
            doneD  = 1'b1;
            errD   = 1'b1;
          end else begin
            waitD = waitQ + 1'b1;
          end
`endif
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= StIdle;
      rwQ      <= 1'b0;
      addrShQ  <= '0;
      dataShQ  <= '0;
      bitCntQ  <= '0;
      beatCntQ <= '0;
      rdShQ    <= '0;
      rdataQ   <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      validQ   <= 1'b0;
      wrenQ    <= 1'b0;
      addrBitQ <= 1'b0;
      dataBitQ <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
      waitQ    <= '0;
      errQ     <= 1'b0;
`endif
    end else begin
      stateQ   <= stateD;
      rwQ      <= rwD;
      addrShQ  <= addrShD;
      dataShQ  <= dataShD;
      bitCntQ  <= bitCntD;
      beatCntQ <= beatCntD;
      rdShQ    <= rdShD;
      rdataQ   <= rdataD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      validQ   <= validD;
      wrenQ    <= wrenD;
      addrBitQ <= addrBitD;
      dataBitQ <= dataBitD;
`ifdef MASTER_TIMEOUT_EN
      waitQ    <= waitD;
      errQ     <= errD;
`endif
    end
  end

  assign bus.busy     = busyQ;
  assign bus.done     = doneQ;
  assign bus.rdata    = rdataQ;
  assign bus.validOut = validQ;
  assign bus.wren     = wrenQ;
  assign bus.Address  = addrBitQ;
  assign bus.DataOut  = dataBitQ;
`ifdef MASTER_TIMEOUT_EN
  assign bus.err      = errQ;
`else
  assign bus.err      = 1'b0;
`endif
endmodule

// File: doc/master_port.md
# master_port

Serial bus initiator that drives the bit-serial slave memory interface from a parallel host request. It serializes a ADN-bit address (and N-bit write data) onto the bus, then either completes a write or collects the slave's serial read response into a parallel word. It sits between a host/arbiter and one slave and mirrors the slave's port names on the bus side.

## Interface
- N, 8, data word width
- ADN, 12, address length; must satisfy ADN >= N
- TIMEOUT, 64, wait-cycle limit (used only with MASTER_TIMEOUT_EN)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  host request strobe
- rw  in  1  1 = write, 0 = read
- addr_in  in  ADN  target address
- wdata_in  in  N  write data
- busy  out  1  request accepted and not yet done
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag, valid with done
- rdata  out  N  read result
- validOut  out  1  bus valid (to slave validIn)
- wren  out  1  bus write enable
- Address  out  1  serial address bit, MSB first
- DataOut  out  1  serial write-data bit, MSB first
- ready  in  1  slave ready
- validIn  in  1  slave read-data valid
- DataIn  in  1  slave serial read data

## Operation
- All outputs registered; reset value 0 for every output, including rdata.
- States: IDLE, WRDY, REQ, ADDR, RWAIT.
- IDLE: start=1 latches rw, addr_in, wdata_in; busy<=1; -> WRDY. start while busy is ignored; later changes to host inputs are ignored.
- WRDY: hold until ready=1, then -> REQ.
- REQ (1 cycle): validOut=1, wren=rw, Address=0, DataOut=0. -> ADDR.
- ADDR (ADN cycles, bit index i=0..ADN-1): validOut=1, wren=rw, Address=addr[ADN-1-i]; DataOut=wdata[N-1-(i-(ADN-N))] when rw=1 and i>=ADN-N, else 0. After i=ADN-1: write -> IDLE with done=1; read -> RWAIT.
- Outside REQ/ADDR: validOut=0, Address=0, DataOut=0. wren stays at the latched rw from REQ through RWAIT, 0 in IDLE/WRDY.
- RWAIT: counts beats with validIn=1. Beat 0 is a dummy and is discarded; beats 1..N shift DataIn into rdata MSB first. After beat N: done=1, busy=0, -> IDLE. rdata holds until the next accepted read completes.
- err=0 on every normal completion.

## Timing
- Cycle 0 = start sampled high in IDLE, ready=1 throughout.
- Cycle 1 WRDY, cycle 2 REQ, cycles 3..ADN+2 address bits.
- Write: done high in cycle ADN+3 (15 at defaults); busy high cycles 1..ADN+2.
- Read: slave beats in cycles ADN+5..ADN+5+N (dummy first); done and final rdata in cycle ADN+6+N (26 at defaults).
- Back-to-back: a new start is accepted in the done cycle; WRDY absorbs slave write-commit time via ready.
- rst mid-transaction: next cycle is IDLE with all outputs 0 and the latched request dropped; the slave is not reset by this block.

## Configuration
- MASTER_TIMEOUT_EN defined: a wait counter clears on entry to WRDY/RWAIT and on every validIn beat. It increments on each other WRDY/RWAIT cycle. On reaching TIMEOUT, the block goes to IDLE and pulses done=1, err=1 in the same cycle, with busy=0 and rdata unchanged.
- Not defined: WRDY/RWAIT wait indefinitely; err is constant 0; no counter is built.

## Test plan
- Write addr 0xA5C, data 0x3C, ready=1: cycles 3..14 Address=1010_0101_1100; DataOut=0 in cycles 3..6 and 0011_1100 in cycles 7..14; wren=1 cycles 2..14; done in cycle 15, err=0.
- Read addr 0xA5C, slave model returns dummy then 0x3C: wren=0 throughout; done in cycle 26, rdata=0x3C.
- ready held low 5 cycles after start: REQ is delayed 5 cycles and all later events shift by 5; a second start during busy produces no extra transaction.
- MASTER_TIMEOUT_EN, TIMEOUT=64, read with validIn never asserted: done=1, err=1 after 64 RWAIT cycles; rdata unchanged.
- rst pulsed in cycle 8 of a write: next cycle all outputs 0 and IDLE; a new write then completes normally with done at cycle 15 relative to its start.
